// File: rtl/request_router_bridge_pkg.sv
// bridge_pkg: shared types for the request router bridge.
//   router_state_e : control state of the request router
//   route_sel_w()  : width of the slave-select field (min 1 bit)
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      SWITCH = 2'd2
   } router_state_e;

   function automatic int unsigned route_sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/request_router_bridge_if.sv
// request_router_bridge_if: master request channel plus the broadcast
// slave-side request bus of the request router bridge.
//   master-side : data_req_i, data_add_i, data_wen_i, data_wdata_i,
//                 data_be_i, data_aux_i -> data_gnt_o
//   slave-side  : data_req_o (one-hot), data_add_o, data_wen_o,
//                 data_wdata_o, data_be_o, data_aux_o <- data_gnt_i,
//                 data_r_valid_i
// modport slave  : bridge view (accepts master requests, drives slaves)
// modport master : environment view (drives requests, grants, responses)
interface request_router_bridge_if #(
   parameter int unsigned N_SLAVE    = 16,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned AUX_WIDTH  = 8
);

   logic                  data_req_i;
   logic [ADDR_WIDTH-1:0] data_add_i;
   logic                  data_wen_i;
   logic [DATA_WIDTH-1:0] data_wdata_i;
   logic [BE_WIDTH-1:0]   data_be_i;
   logic [AUX_WIDTH-1:0]  data_aux_i;
   logic                  data_gnt_o;

   logic [N_SLAVE-1:0]    data_req_o;
   logic [ADDR_WIDTH-1:0] data_add_o;
   logic                  data_wen_o;
   logic [DATA_WIDTH-1:0] data_wdata_o;
   logic [BE_WIDTH-1:0]   data_be_o;
   logic [AUX_WIDTH-1:0]  data_aux_o;
   logic [N_SLAVE-1:0]    data_gnt_i;
   logic [N_SLAVE-1:0]    data_r_valid_i;

   modport slave (
      input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
      output data_gnt_o,
      output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
      input  data_gnt_i, data_r_valid_i
   );

   modport master (
      output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
      input  data_gnt_o,
      input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
      output data_gnt_i, data_r_valid_i
   );

endinterface

// File: rtl/request_router_bridge_outstanding_cnt.sv
// outstanding_cnt_bridge: saturating up/down counter of granted-but-
// unanswered transactions.
//   inc_i     : slave handshake this cycle
//   dec_i     : any response valid this cycle
//   pending_i : a request is held in the output register
//   cnt_o     : registered count
//   cnt_nxt_o : count after this cycle's update
//   full_o    : cnt + pending has reached MAX_OUTSTANDING
module outstanding_cnt_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             pending_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             full_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] cnt_q;

   // Simultaneous increment and decrement cancel; a decrement at zero is
   // a stray response and is dropped.
   always_comb begin
      cnt_nxt_o = cnt_q;
      if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
         cnt_nxt_o = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_nxt_o = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nxt_o;
      end
   end

   assign cnt_o  = cnt_q;
   assign full_o = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, pending_i}) >= LIMIT;

endmodule

// File: rtl/request_router_bridge.sv
// request_router_bridge: routes one master's requests to N_SLAVE slaves
// through a single registered stage, decoding the slave from
// add[ROUTE_LSB +: log2(N_SLAVE)]. A change of destination is held off
// until every response owed by the previous slave has returned, so the
// response tree sees responses in issue order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request_router_bridge_if.slave (master channel + slave bus)
//   busy_o     : router not idle
module request_router_bridge
   import bridge_pkg::*;
#(
   parameter int unsigned N_SLAVE         = 16,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned AUX_WIDTH       = 8,
   parameter int unsigned ROUTE_LSB       = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   request_router_bridge_if.slave   bus,
   output logic                     busy_o
);

   localparam int unsigned SEL_W = route_sel_w(N_SLAVE);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   router_state_e state_q, state_nxt;

   logic                  out_vld;
   logic [SEL_W-1:0]      cur_dest;
   logic [SEL_W-1:0]      dest;
   logic [ADDR_WIDTH-1:0] add_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_WIDTH-1:0]   be_q;
   logic [AUX_WIDTH-1:0]  aux_q;

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  full;
   logic                  slave_hs;
   logic                  slot_ok;
   logic                  route_ok;
   logic                  gnt;
   logic                  out_vld_nxt;
   logic [N_SLAVE-1:0]    req_oh;

   generate
      if (N_SLAVE > 1) begin : g_route
         assign dest = bus.data_add_i[ROUTE_LSB +: SEL_W];
      end else begin : g_single
         assign dest = '0;
      end
   endgenerate

   assign slave_hs = out_vld && bus.data_gnt_i[cur_dest];
   assign slot_ok  = !out_vld || slave_hs;
   // Same slave may stream; a new slave only once nothing is owed.
   assign route_ok = (dest == cur_dest) || ((cnt == '0) && !out_vld);
   assign gnt      = bus.data_req_i && slot_ok && route_ok && !full;

   assign out_vld_nxt = gnt || (out_vld && !slave_hs);

   outstanding_cnt_bridge #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (slave_hs),
      .dec_i     (|bus.data_r_valid_i),
      .pending_i (out_vld),
      .cnt_o     (cnt),
      .cnt_nxt_o (cnt_nxt),
      .full_o    (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         cur_dest <= '0;
         add_q    <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         aux_q    <= '0;
      end else begin
         out_vld <= out_vld_nxt;
         if (gnt) begin
            cur_dest <= dest;
            add_q    <= bus.data_add_i;
            wen_q    <= bus.data_wen_i;
            wdata_q  <= bus.data_wdata_i;
            be_q     <= bus.data_be_i;
            aux_q    <= bus.data_aux_i;
         end
      end
   end

   always_comb begin
      req_oh = '0;
      if (out_vld) begin
         req_oh[cur_dest] = 1'b1;
      end
   end

   assign bus.data_gnt_o   = gnt;
   assign bus.data_req_o   = req_oh;
   assign bus.data_add_o   = add_q;
   assign bus.data_wen_o   = wen_q;
   assign bus.data_wdata_o = wdata_q;
   assign bus.data_be_o    = be_q;
   assign bus.data_aux_o   = aux_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // BUSY drains to IDLE on next-cycle values so IDLE always means the
   // register and counter are both empty. A switch request that is
   // withdrawn while responses are still owed falls back to BUSY.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (gnt) state_nxt = BUSY;
         end
         BUSY: begin
            if (gnt) begin
               state_nxt = BUSY;
            end else if (bus.data_req_i && (dest != cur_dest)) begin
               state_nxt = SWITCH;
            end else if (!out_vld_nxt && (cnt_nxt == '0)) begin
               state_nxt = IDLE;
            end
         end
         SWITCH: begin
            if (gnt) begin
               state_nxt = BUSY;
            end else if (!bus.data_req_i) begin
               state_nxt = (out_vld_nxt || (cnt_nxt != '0)) ? BUSY : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q != IDLE);
   end

endmodule
